seg_data_latch: RTL

SEG_DATA_LATCH -- requirements
Module: seg_data_latch

---
 rtl/seg_data_latch.sv | 115 +++++++++++
 1 files changed

// File: rtl/seg_data_latch.sv
// seg_data_latch: write-port register file for a 4-digit display driver.
// Staged 16-bit commit, enable/blink control, free-running scan prescaler.
module seg_data_latch #(
  parameter int PRESCALE    = 32768,
  parameter int BLINK_TICKS = 128
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Wr_En,
  input  logic [1:0]  i_Wr_Addr,
  input  logic [7:0]  i_Wr_Data,
  output logic        o_Wr_Ack,
  output logic [15:0] o_Data,
  output logic        o_OE,
  output logic        o_Scan_Tick
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] P_PRE  = PW'(PRESCALE - 2);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [7:0]    B_LAST = 8'(BLINK_TICKS - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick_q;
  logic [7:0]    stage_lo;
  logic [15:0]   data_q;
  logic          en_q;
  logic          blink_q;
  logic          ph_q;
  logic [7:0]    bcnt;
  logic          ack_q;
  logic          oe_q;

  logic wr_lo;
  logic wr_hi;
  logic wr_ctl;

  // Address decode; addr 3 decodes to nothing but is still acked.
  always_comb begin
    wr_lo  = 1'b0;
    wr_hi  = 1'b0;
    wr_ctl = 1'b0;
    if (i_Wr_En) begin
      unique case (i_Wr_Addr)
        2'd0: wr_lo  = 1'b1;
        2'd1: wr_hi  = 1'b1;
        2'd2: wr_ctl = 1'b1;
        2'd3: ;
      endcase
    end
  end

  // Prescaler; tick is pre-registered so it is high while count is last.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      pre_cnt <= (pre_cnt == P_LAST) ? '0 : pre_cnt + P_ONE;
      tick_q  <= (pre_cnt == P_PRE);
    end
  end

  // Staging low byte and atomic 16-bit commit.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      stage_lo <= 8'h00;
      data_q   <= 16'h0000;
    end else begin
      if (wr_lo) stage_lo <= i_Wr_Data;
      if (wr_hi) data_q <= {i_Wr_Data, stage_lo};
    end
  end

  // Control write restarts blink phase, overriding a same-cycle toggle.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      en_q    <= 1'b0;
      blink_q <= 1'b0;
      ph_q    <= 1'b1;
      bcnt    <= 8'h00;
    end else if (wr_ctl) begin
      en_q    <= i_Wr_Data[0];
      blink_q <= i_Wr_Data[1];
      ph_q    <= 1'b1;
      bcnt    <= 8'h00;
    end else if (tick_q) begin
      if (bcnt == B_LAST) begin
        bcnt <= 8'h00;
        ph_q <= ~ph_q;
      end else begin
        bcnt <= bcnt + 8'h01;
      end
    end
  end

  // Ack every write one cycle later; output enable lags its inputs by one.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      ack_q <= 1'b0;
      oe_q  <= 1'b0;
    end else begin
      ack_q <= i_Wr_En;
      oe_q  <= en_q & (~blink_q | ph_q);
    end
  end

  assign o_Wr_Ack    = ack_q;
  assign o_Data      = data_q;
  assign o_OE        = oe_q;
  assign o_Scan_Tick = tick_q;

endmodule
